// File: rtl/acc_bank_if.sv
// Operation/result bus of the accumulator bank.
// The master modport issues ops; the slave modport (the bank) returns results.
interface acc_bank_if #(
   parameter int WIDTH = 32,
   parameter int AW    = 2
);
   logic             op_valid;
   logic [2:0]       op_code;
   logic [AW-1:0]    acc_sel;
   logic [WIDTH-1:0] din;
   logic [AW-1:0]    rd_sel;
   logic [WIDTH-1:0] rd_data;
   logic             res_valid;
   logic [WIDTH-1:0] res_data;
   logic             flag_z;
   logic             flag_n;
   logic             flag_c;
   logic             flag_v;
   logic             err;

   modport master (
      output op_valid, op_code, acc_sel, din, rd_sel,
      input  rd_data, res_valid, res_data, flag_z, flag_n, flag_c, flag_v, err
   );

   modport slave (
      input  op_valid, op_code, acc_sel, din, rd_sel,
      output rd_data, res_valid, res_data, flag_z, flag_n, flag_c, flag_v, err
   );
endinterface

// File: rtl/acc_bank.sv
// Bank of NUM_ACC accumulators with a 2-edge ALU pipeline, z/n/c/v flags,
// optional signed saturation and a write-through registered read port.
module acc_bank #(
   parameter int WIDTH   = 32,
   parameter int NUM_ACC = 4,
   parameter bit SAT_EN  = 1'b0
) (
   input logic        execlk,
   input logic        rst,
   acc_bank_if.slave  bus
);
   localparam int AW = (NUM_ACC > 1) ? $clog2(NUM_ACC) : 1;

   typedef enum logic [2:0] {
      OP_NOP, OP_LOAD, OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR, OP_CLR
   } op_e;

   logic                            s1_vld_q, s1_vld_d;
   op_e                             s1_op_q, s1_op_d;
   logic [AW-1:0]                   s1_sel_q, s1_sel_d;
   logic [WIDTH-1:0]                s1_din_q, s1_din_d;
   logic [NUM_ACC-1:0][WIDTH-1:0]   acc_q, acc_d;
   logic [WIDTH-1:0]                rd_data_q, rd_data_d;
   logic [WIDTH-1:0]                res_data_q, res_data_d;
   logic                            res_valid_q, res_valid_d;
   logic                            err_q, err_d;
   logic                            flag_z_q, flag_z_d;
   logic                            flag_n_q, flag_n_d;
   logic                            flag_c_q, flag_c_d;
   logic                            flag_v_q, flag_v_d;

   logic                            sel_ok;
   logic                            commit;
   logic [WIDTH-1:0]                acc_a;
   logic [WIDTH:0]                  sum;
   logic [WIDTH:0]                  diff;
   logic [WIDTH-1:0]                result;
   logic                            carry;
   logic                            ovf;

   always_comb begin
      s1_vld_d = bus.op_valid;
      s1_op_d  = s1_op_q;
      s1_sel_d = s1_sel_q;
      s1_din_d = s1_din_q;
      if (bus.op_valid) begin
         s1_op_d  = op_e'(bus.op_code);
         s1_sel_d = bus.acc_sel;
         s1_din_d = bus.din;
      end

      sel_ok = (int'(s1_sel_q) < NUM_ACC);

      // The previous op committed on the edge this one was captured, so acc_q
      // already holds the chained operand; no separate bypass path is needed.
      acc_a = '0;
      for (int i = 0; i < NUM_ACC; i++)
         if (s1_sel_q == AW'(i)) acc_a = acc_q[i];

      sum    = {1'b0, acc_a} + {1'b0, s1_din_q};
      diff   = {1'b0, acc_a} - {1'b0, s1_din_q};
      result = '0;
      carry  = 1'b0;
      ovf    = 1'b0;
      case (s1_op_q)
         OP_LOAD: result = s1_din_q;
         OP_ADD: begin
            result = sum[WIDTH-1:0];
            carry  = sum[WIDTH];
            ovf    = (acc_a[WIDTH-1] == s1_din_q[WIDTH-1]) &&
                     (sum[WIDTH-1] != acc_a[WIDTH-1]);
         end
         OP_SUB: begin
            result = diff[WIDTH-1:0];
            carry  = diff[WIDTH];
            ovf    = (acc_a[WIDTH-1] != s1_din_q[WIDTH-1]) &&
                     (diff[WIDTH-1] != acc_a[WIDTH-1]);
         end
         OP_AND:  result = acc_a & s1_din_q;
         OP_OR:   result = acc_a | s1_din_q;
         OP_XOR:  result = acc_a ^ s1_din_q;
         default: result = '0;
      endcase

      // On overflow the sign of A tells the direction of the true result.
      if (SAT_EN && ovf)
         result = acc_a[WIDTH-1] ? {1'b1, {(WIDTH-1){1'b0}}} : {1'b0, {(WIDTH-1){1'b1}}};

      commit      = s1_vld_q && (s1_op_q != OP_NOP) && sel_ok;
      acc_d       = acc_q;
      res_data_d  = res_data_q;
      flag_z_d    = flag_z_q;
      flag_n_d    = flag_n_q;
      flag_c_d    = flag_c_q;
      flag_v_d    = flag_v_q;
      res_valid_d = commit;
      err_d       = s1_vld_q && !sel_ok;
      if (commit) begin
         for (int i = 0; i < NUM_ACC; i++)
            if (s1_sel_q == AW'(i)) acc_d[i] = result;
         res_data_d = result;
         flag_z_d   = (result == '0);
         flag_n_d   = result[WIDTH-1];
         flag_c_d   = carry;
         flag_v_d   = ovf;
      end

      rd_data_d = '0;
      for (int i = 0; i < NUM_ACC; i++)
         if (bus.rd_sel == AW'(i)) rd_data_d = acc_d[i];
   end

   always_ff @(posedge execlk or posedge rst) begin
      if (rst) begin
         s1_vld_q    <= 1'b0;
         s1_op_q     <= OP_NOP;
         s1_sel_q    <= '0;
         s1_din_q    <= '0;
         acc_q       <= '0;
         rd_data_q   <= '0;
         res_data_q  <= '0;
         res_valid_q <= 1'b0;
         err_q       <= 1'b0;
         flag_z_q    <= 1'b0;
         flag_n_q    <= 1'b0;
         flag_c_q    <= 1'b0;
         flag_v_q    <= 1'b0;
      end else begin
         s1_vld_q    <= s1_vld_d;
         s1_op_q     <= s1_op_d;
         s1_sel_q    <= s1_sel_d;
         s1_din_q    <= s1_din_d;
         acc_q       <= acc_d;
         rd_data_q   <= rd_data_d;
         res_data_q  <= res_data_d;
         res_valid_q <= res_valid_d;
         err_q       <= err_d;
         flag_z_q    <= flag_z_d;
         flag_n_q    <= flag_n_d;
         flag_c_q    <= flag_c_d;
         flag_v_q    <= flag_v_d;
      end
   end

   assign bus.rd_data   = rd_data_q;
   assign bus.res_data  = res_data_q;
   assign bus.res_valid = res_valid_q;
   assign bus.err       = err_q;
   assign bus.flag_z    = flag_z_q;
   assign bus.flag_n    = flag_n_q;
   assign bus.flag_c    = flag_c_q;
   assign bus.flag_v    = flag_v_q;
endmodule

// File: tb/tb_acc_bank.sv
// Bench for acc_bank: two instances (4 acc wrapping, 3 acc saturating) share
// stimulus; directed table, reset-in-flight sequence, then random vs. model.
module tb_acc_bank;
   localparam longint MAXP = 2147483647;
   localparam longint MINN = -MAXP - 1;

   logic execlk = 1'b0;
   logic rst    = 1'b1;
   always #5 execlk = ~execlk;

   acc_bank_if #(.WIDTH(32), .AW(2)) bus0 ();
   acc_bank_if #(.WIDTH(32), .AW(2)) bus1 ();

   acc_bank #(.WIDTH(32), .NUM_ACC(4), .SAT_EN(1'b0)) u0 (.execlk(execlk), .rst(rst), .bus(bus0));
   acc_bank #(.WIDTH(32), .NUM_ACC(3), .SAT_EN(1'b1)) u1 (.execlk(execlk), .rst(rst), .bus(bus1));

   int checks   = 0;
   int failures = 0;

   typedef struct {
      logic [2:0]  op;
      logic [1:0]  sel;
      logic [31:0] din;
      logic [1:0]  rd;
      logic        vld;
      logic [31:0] res;
      logic [3:0]  flg;
      logic [31:0] rdv;
      logic [31:0] res1;
      logic        err1;
   } vec_t;
   vec_t tbl[$];

   // reference state: instance 0 wraps with 4 accs, instance 1 saturates with 3
   logic [31:0] macc[2][4];
   logic        pv;
   logic [2:0]  pop;
   logic [1:0]  psel;
   logic [31:0] pdin;
   logic        e_vld[2], e_err[2];
   logic [31:0] e_res[2], e_rd[2];
   logic [3:0]  e_flg[2];

   task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=%h exp=%h", name, got, exp);
      end
   endtask

   task automatic drive(input logic v, input logic [2:0] op, input logic [1:0] sel,
                        input logic [31:0] d, input logic [1:0] rd);
      bus0.op_valid = v;  bus0.op_code = op; bus0.acc_sel = sel; bus0.din = d; bus0.rd_sel = rd;
      bus1.op_valid = v;  bus1.op_code = op; bus1.acc_sel = sel; bus1.din = d; bus1.rd_sel = rd;
   endtask

   task automatic model_reset();
      for (int k = 0; k < 2; k++) begin
         for (int i = 0; i < 4; i++) macc[k][i] = '0;
         e_vld[k] = 0; e_err[k] = 0; e_res[k] = '0; e_rd[k] = '0; e_flg[k] = '0;
      end
      pv = 0; pop = '0; psel = '0; pdin = '0;
   endtask

   task automatic model_edge();
      logic [31:0] a, r;
      logic c, v;
      longint sr;
      int nacc;
      if (rst) begin
         model_reset();
         return;
      end
      for (int k = 0; k < 2; k++) begin
         nacc = (k == 0) ? 4 : 3;
         e_vld[k] = 0;
         e_err[k] = 0;
         if (pv) begin
            if (int'(psel) >= nacc) e_err[k] = 1;
            else if (pop != 3'd0) begin
               a = macc[k][psel];
               r = '0; c = 0; sr = 0;
               case (pop)
                  3'd1: r = pdin;
                  3'd2: begin
                     r  = a + pdin;
                     c  = (longint'(a) + longint'(pdin)) > 64'hFFFF_FFFF;
                     sr = longint'($signed(a)) + longint'($signed(pdin));
                  end
                  3'd3: begin
                     r  = a - pdin;
                     c  = pdin > a;
                     sr = longint'($signed(a)) - longint'($signed(pdin));
                  end
                  3'd4: r = a & pdin;
                  3'd5: r = a | pdin;
                  3'd6: r = a ^ pdin;
                  default: r = '0;
               endcase
               v = (pop == 3'd2 || pop == 3'd3) && (sr > MAXP || sr < MINN);
               if (v && k == 1) r = (sr > 0) ? 32'h7FFF_FFFF : 32'h8000_0000;
               macc[k][psel] = r;
               e_res[k] = r;
               e_flg[k] = {r == 32'd0, r[31], c, v};
               e_vld[k] = 1;
            end
         end
         e_rd[k] = (int'(bus0.rd_sel) < nacc) ? macc[k][bus0.rd_sel] : 32'd0;
      end
      pv = bus0.op_valid;
      if (bus0.op_valid) begin
         pop = bus0.op_code; psel = bus0.acc_sel; pdin = bus0.din;
      end
   endtask

   task automatic check_all();
      chk("u0.res_valid", {31'd0, bus0.res_valid}, {31'd0, e_vld[0]});
      chk("u0.err",       {31'd0, bus0.err},       {31'd0, e_err[0]});
      chk("u0.res_data",  bus0.res_data,           e_res[0]);
      chk("u0.flags",     {28'd0, bus0.flag_z, bus0.flag_n, bus0.flag_c, bus0.flag_v}, {28'd0, e_flg[0]});
      chk("u0.rd_data",   bus0.rd_data,            e_rd[0]);
      chk("u1.res_valid", {31'd0, bus1.res_valid}, {31'd0, e_vld[1]});
      chk("u1.err",       {31'd0, bus1.err},       {31'd0, e_err[1]});
      chk("u1.res_data",  bus1.res_data,           e_res[1]);
      chk("u1.flags",     {28'd0, bus1.flag_z, bus1.flag_n, bus1.flag_c, bus1.flag_v}, {28'd0, e_flg[1]});
      chk("u1.rd_data",   bus1.rd_data,            e_rd[1]);
   endtask

   task automatic check_zero(input string tag);
      chk({tag, ".u0.outs"}, {bus0.res_valid, bus0.err, bus0.flag_z, bus0.flag_n, bus0.flag_c, bus0.flag_v, 26'd0}, 32'd0);
      chk({tag, ".u0.res"},  bus0.res_data, 32'd0);
      chk({tag, ".u0.rd"},   bus0.rd_data,  32'd0);
      chk({tag, ".u1.outs"}, {bus1.res_valid, bus1.err, bus1.flag_z, bus1.flag_n, bus1.flag_c, bus1.flag_v, 26'd0}, 32'd0);
      chk({tag, ".u1.res"},  bus1.res_data, 32'd0);
      chk({tag, ".u1.rd"},   bus1.rd_data,  32'd0);
   endtask

   task automatic tick();
      @(posedge execlk);
      model_edge();
      @(negedge execlk);
      check_all();
   endtask

   task automatic add(input logic [2:0] op, input logic [1:0] sel, input logic [31:0] din,
                      input logic [1:0] rd, input logic vld, input logic [31:0] res,
                      input logic [3:0] flg, input logic [31:0] rdv, input logic [31:0] res1,
                      input logic err1);
      vec_t t;
      t.op = op; t.sel = sel; t.din = din; t.rd = rd; t.vld = vld; t.res = res;
      t.flg = flg; t.rdv = rdv; t.res1 = res1; t.err1 = err1;
      tbl.push_back(t);
   endtask

   initial begin
      vec_t t;
      logic [31:0] d;
      // op sel din rd(at commit) | u0: vld res flags{zncv} rd | u1: res err
      add(3'd1, 2'd0, 32'd5,          2'd0, 1, 32'd5,          4'b0000, 32'd5,          32'd5,          0);
      add(3'd2, 2'd0, 32'd3,          2'd0, 1, 32'd8,          4'b0000, 32'd8,          32'd8,          0);
      add(3'd1, 2'd1, 32'h7FFF_FFFF,  2'd1, 1, 32'h7FFF_FFFF,  4'b0000, 32'h7FFF_FFFF,  32'h7FFF_FFFF,  0);
      add(3'd2, 2'd1, 32'd1,          2'd1, 1, 32'h8000_0000,  4'b0101, 32'h8000_0000,  32'h7FFF_FFFF,  0);
      add(3'd1, 2'd2, 32'd2,          2'd2, 1, 32'd2,          4'b0000, 32'd2,          32'd2,          0);
      add(3'd3, 2'd2, 32'd3,          2'd2, 1, 32'hFFFF_FFFF,  4'b0110, 32'hFFFF_FFFF,  32'hFFFF_FFFF,  0);
      add(3'd3, 2'd2, 32'hFFFF_FFFF,  2'd2, 1, 32'd0,          4'b1000, 32'd0,          32'd0,          0);
      add(3'd1, 2'd1, 32'd10,         2'd1, 1, 32'd10,         4'b0000, 32'd10,         32'd10,         0);
      add(3'd1, 2'd2, 32'd20,         2'd2, 1, 32'd20,         4'b0000, 32'd20,         32'd20,         0);
      add(3'd2, 2'd1, 32'd1,          2'd1, 1, 32'd11,         4'b0000, 32'd11,         32'd11,         0);
      add(3'd2, 2'd2, 32'd2,          2'd2, 1, 32'd22,         4'b0000, 32'd22,         32'd22,         0);
      add(3'd4, 2'd0, 32'hC,          2'd0, 1, 32'd8,          4'b0000, 32'd8,          32'd8,          0);
      add(3'd5, 2'd0, 32'h3,          2'd0, 1, 32'hB,          4'b0000, 32'hB,          32'hB,          0);
      add(3'd6, 2'd0, 32'hB,          2'd0, 1, 32'd0,          4'b1000, 32'd0,          32'd0,          0);
      add(3'd2, 2'd3, 32'd1,          2'd3, 1, 32'd1,          4'b0000, 32'd1,          32'd0,          1);
      add(3'd2, 2'd1, 32'd5,          2'd1, 1, 32'h10,         4'b0000, 32'h10,         32'h10,         0);
      add(3'd0, 2'd0, 32'd99,         2'd0, 0, 32'h10,         4'b0000, 32'd0,          32'h10,         0);
      add(3'd7, 2'd1, 32'd0,          2'd1, 1, 32'd0,          4'b1000, 32'd0,          32'd0,          0);

      model_reset();
      drive(0, 3'd0, 2'd0, 32'd0, 2'd0);
      #12;
      check_zero("reset");
      @(negedge execlk);
      rst = 1'b0;

      for (int i = 0; i <= tbl.size(); i++) begin
         if (i < tbl.size()) drive(1, tbl[i].op, tbl[i].sel, tbl[i].din, (i > 0) ? tbl[i-1].rd : 2'd0);
         else                drive(0, 3'd0, 2'd0, 32'd0, tbl[i-1].rd);
         tick();
         if (i > 0) begin
            t = tbl[i-1];
            chk($sformatf("tbl%0d.u0.res_valid", i-1), {31'd0, bus0.res_valid}, {31'd0, t.vld});
            chk($sformatf("tbl%0d.u0.res_data", i-1),  bus0.res_data, t.res);
            chk($sformatf("tbl%0d.u0.flags", i-1), {28'd0, bus0.flag_z, bus0.flag_n, bus0.flag_c, bus0.flag_v}, {28'd0, t.flg});
            chk($sformatf("tbl%0d.u0.rd_data", i-1),   bus0.rd_data, t.rdv);
            chk($sformatf("tbl%0d.u0.err", i-1),       {31'd0, bus0.err}, 32'd0);
            chk($sformatf("tbl%0d.u1.res_data", i-1),  bus1.res_data, t.res1);
            chk($sformatf("tbl%0d.u1.err", i-1),       {31'd0, bus1.err}, {31'd0, t.err1});
            chk($sformatf("tbl%0d.u1.res_valid", i-1), {31'd0, bus1.res_valid}, {31'd0, t.vld & ~t.err1});
         end
      end

      // reset while an ADD sits in stage 1
      drive(1, 3'd1, 2'd2, 32'h55, 2'd2);
      tick();
      drive(1, 3'd2, 2'd2, 32'd1, 2'd2);
      tick();
      drive(0, 3'd0, 2'd0, 32'd0, 2'd2);
      rst = 1'b1;
      #1;
      model_reset();
      check_zero("rst_async");
      tick();
      rst = 1'b0;
      for (int s = 0; s < 4; s++) begin
         drive(0, 3'd0, 2'd0, 32'd0, 2'(s));
         tick();
         check_zero($sformatf("post_rst_rd%0d", s));
      end
      drive(1, 3'd1, 2'd0, 32'd9, 2'd0);
      tick();
      drive(0, 3'd0, 2'd0, 32'd0, 2'd0);
      tick();
      chk("first_after_rst.res", bus0.res_data, 32'd9);
      chk("first_after_rst.rd",  bus0.rd_data,  32'd9);

      for (int n = 0; n < 500; n++) begin
         case ($urandom_range(0, 7))
            0: d = 32'd0;
            1: d = 32'd1;
            2: d = 32'h7FFF_FFFF;
            3: d = 32'h8000_0000;
            4: d = 32'hFFFF_FFFF;
            default: d = $urandom;
         endcase
         drive($urandom_range(0, 9) < 8, 3'($urandom_range(0, 7)), 2'($urandom_range(0, 3)),
               d, 2'($urandom_range(0, 3)));
         tick();
      end
      drive(0, 3'd0, 2'd0, 32'd0, 2'd0);
      tick();
      tick();

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
